// File: rtl/full_st0_seq_ctrl_pkg.sv
// Shared types and constants for the stage-0 fully-connected sequencer.
// Optional feature macro used by the files of this block: FULL_ST0_SEQ_ERROR_EN.
package full_st0_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_ERROR = 3'd4
  } full_st0_seq_state_t;

  // First tap/bias row reserved for error staging; data rows live below it.
  localparam logic [3:0] ERR_ROW_BASE = 4'd12;

  localparam int DEF_PIPE_LAT = 6;
  localparam int DEF_PRE_LAT  = 4;

endpackage

// File: rtl/full_st0_seq_ctrl_if.sv
// Handshake and address bundle between the stage-0 sequencer (master) and
// the stage-0 output-control block / data source (slave).
// Optional feature macro: FULL_ST0_SEQ_ERROR_EN (error fields stay 0 without it).
interface full_st0_seq_ctrl_if;
  logic       data_valid;
  logic       stage_0_data_out_rdy;
  logic       error_valid;
  logic [5:0] data_write_addr;
  logic [5:0] data_read_addr;
  logic [3:0] tap_address;
  logic [3:0] bias_wr_address;
  logic       bias_wr_vld;
  logic       active_normal;
  logic       active_start_d;
  logic       active_pre;
  logic       active;
  logic [1:0] error_phase;
  logic [1:0] error_phase_read;
  logic       error_update_first;
  logic       error_update_latch;
  logic       read_finish;
  logic       busy;
  logic       load_drop;

  modport master (
    input  data_valid, stage_0_data_out_rdy, error_valid,
    output data_write_addr, data_read_addr, tap_address, bias_wr_address,
           bias_wr_vld, active_normal, active_start_d, active_pre, active,
           error_phase, error_phase_read, error_update_first,
           error_update_latch, read_finish, busy, load_drop
  );

  modport slave (
    output data_valid, stage_0_data_out_rdy, error_valid,
    input  data_write_addr, data_read_addr, tap_address, bias_wr_address,
           bias_wr_vld, active_normal, active_start_d, active_pre, active,
           error_phase, error_phase_read, error_update_first,
           error_update_latch, read_finish, busy, load_drop
  );
endinterface

// File: rtl/full_st0_seq_delay.sv
// Width x depth shift register used to align strobes and addresses with the
// datapath latency. Synchronous active-high reset empties the whole line.
module full_st0_seq_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] sr_q [DEPTH];

  // Shift one stage per cycle; stalls enter as ordinary zero samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign data_o = sr_q[DEPTH-1];

endmodule

// File: rtl/full_st0_seq_ctrl.sv
// Stage-0 fully-connected sequencer: loads N_IN words, walks tap/data read
// addresses for one forward pass, aligns valid strobes to the pipeline and,
// when FULL_ST0_SEQ_ERROR_EN is defined, runs the error/tap-update phases.
//
// state    | meaning
// IDLE     | waiting for the first data word
// LOAD     | counting data words into the data memory
// RUN      | issuing tap/data reads, stalled by downstream ready
// DRAIN    | letting the delay lines empty (PIPE_LAT cycles)
// ERROR    | error phases: one first cycle plus a tap sweep per phase
module full_st0_seq_ctrl
  import full_st0_seq_ctrl_pkg::*;
#(
  parameter int N_IN       = 4,
  parameter int TAP_ROWS   = 12,
  parameter int PIPE_LAT   = DEF_PIPE_LAT,
  parameter int PRE_LAT    = DEF_PRE_LAT,
  parameter int ERR_PHASES = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  full_st0_seq_ctrl_if.master        bus
);

  localparam logic [5:0] WORD_LAST  = 6'(N_IN - 1);
  // Data rows never spill into the error staging rows.
  localparam logic [3:0] TAP_LAST   = (TAP_ROWS > int'(ERR_ROW_BASE)) ?
                                      (ERR_ROW_BASE - 4'd1) : 4'(TAP_ROWS - 1);
  localparam logic [7:0] DRAIN_LAST = 8'(PIPE_LAT - 1);

  full_st0_seq_state_t state_q, state_d;
  logic [5:0] wr_q, wr_d;
  logic [5:0] rd_q, rd_d;
  logic [3:0] tap_q, tap_d;
  logic [7:0] drain_q, drain_d;
  logic       load_drop_q;
  logic       start_q;
  logic       issue;
  logic       finish;

`ifdef FULL_ST0_SEQ_ERROR_EN
  localparam logic [1:0] PH_LAST = 2'(ERR_PHASES - 1);
  logic [1:0] ph_q, ph_d;
  logic       lat_q, lat_d;
  logic       err_pend_q;
  logic [1:0] ph_dly_q;
  logic       err_first;
  logic       err_latch;
  logic       err_done;
`endif

  // Next-state and issue decode.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    tap_d   = tap_q;
    drain_d = drain_q;
    issue   = 1'b0;
    finish  = 1'b0;
`ifdef FULL_ST0_SEQ_ERROR_EN
    ph_d      = ph_q;
    lat_d     = lat_q;
    err_first = 1'b0;
    err_latch = 1'b0;
    err_done  = 1'b0;
`endif
    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (bus.data_valid) begin
          if (wr_q == WORD_LAST) begin
            wr_d    = '0;
            state_d = ST_RUN;
          end else begin
            wr_d    = wr_q + 6'd1;
            state_d = ST_LOAD;
          end
        end
      end
      ST_RUN: begin
        if (bus.stage_0_data_out_rdy) begin
          issue = 1'b1;
          if (tap_q == TAP_LAST) begin
            tap_d = '0;
            if (rd_q == WORD_LAST) begin
              rd_d    = '0;
              finish  = 1'b1;
              drain_d = DRAIN_LAST;
              state_d = ST_DRAIN;
            end else begin
              rd_d = rd_q + 6'd1;
            end
          end else begin
            tap_d = tap_q + 4'd1;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) begin
`ifdef FULL_ST0_SEQ_ERROR_EN
          state_d = err_pend_q ? ST_ERROR : ST_IDLE;
`else
          state_d = ST_IDLE;
`endif
        end else begin
          drain_d = drain_q - 8'd1;
        end
      end
`ifdef FULL_ST0_SEQ_ERROR_EN
      ST_ERROR: begin
        if (!lat_q) begin
          err_first = 1'b1;
          lat_d     = 1'b1;
        end else begin
          err_latch = 1'b1;
          if (tap_q == TAP_LAST) begin
            tap_d = '0;
            lat_d = 1'b0;
            if (ph_q == PH_LAST) begin
              ph_d     = '0;
              err_done = 1'b1;
              state_d  = ST_IDLE;
            end else begin
              ph_d = ph_q + 2'd1;
            end
          end else begin
            tap_d = tap_q + 4'd1;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and the sticky drop flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_q        <= '0;
      rd_q        <= '0;
      tap_q       <= '0;
      drain_q     <= '0;
      load_drop_q <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      tap_q       <= tap_d;
      drain_q     <= drain_d;
      load_drop_q <= load_drop_q | (bus.data_valid &&
                     (state_q == ST_RUN || state_q == ST_DRAIN || state_q == ST_ERROR));
      start_q     <= issue && (tap_q == '0);
    end
  end

`ifdef FULL_ST0_SEQ_ERROR_EN
  // Error phase tracking; a new error request wins over the exit clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ph_q       <= '0;
      lat_q      <= 1'b0;
      err_pend_q <= 1'b0;
      ph_dly_q   <= '0;
    end else begin
      ph_q       <= ph_d;
      lat_q      <= lat_d;
      err_pend_q <= (err_pend_q & ~err_done) | bus.error_valid;
      ph_dly_q   <= ph_q;
    end
  end

  assign bus.error_phase        = ph_dly_q;
  assign bus.error_phase_read   = ph_q;
  assign bus.error_update_first = err_first;
  assign bus.error_update_latch = err_latch;
`else
  logic       unused_error_valid;
  logic [1:0] unused_err_phases;
  assign unused_error_valid = bus.error_valid;
  assign unused_err_phases  = 2'(ERR_PHASES);

  assign bus.error_phase        = 2'd0;
  assign bus.error_phase_read   = 2'd0;
  assign bus.error_update_first = 1'b0;
  assign bus.error_update_latch = 1'b0;
`endif

  full_st0_seq_delay #(.WIDTH(1), .DEPTH(PIPE_LAT)) u_dly_active (
    .clk(clk), .reset(reset), .data_i(issue), .data_o(bus.active)
  );

  full_st0_seq_delay #(.WIDTH(1), .DEPTH(PRE_LAT)) u_dly_pre (
    .clk(clk), .reset(reset), .data_i(issue), .data_o(bus.active_pre)
  );

  full_st0_seq_delay #(.WIDTH(1), .DEPTH(PRE_LAT)) u_dly_bias_vld (
    .clk(clk), .reset(reset), .data_i(issue), .data_o(bus.bias_wr_vld)
  );

  full_st0_seq_delay #(.WIDTH(4), .DEPTH(PRE_LAT)) u_dly_bias_addr (
    .clk(clk), .reset(reset), .data_i(tap_q), .data_o(bus.bias_wr_address)
  );

  assign bus.data_write_addr = wr_q;
  assign bus.data_read_addr  = rd_q;
  assign bus.tap_address     = tap_q;
  assign bus.active_normal   = issue;
  assign bus.read_finish     = finish;
  assign bus.active_start_d  = start_q;
  assign bus.busy            = (state_q != ST_IDLE);
  assign bus.load_drop       = load_drop_q;

endmodule
